// File: rtl/uart_host_cmd_master.sv
// Host-side UART command initiator: frames one command, collects its response.
// Optional response timeout enabled by defining UART_HOST_TIMEOUT_EN.
module uart_host_cmd_master #(
   parameter int TIMEOUT_CYC = 65535,
   parameter int TO_W        = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [7:0]  cmd_addr,
   input  logic [7:0]  cmd_wdata,
   input  logic [7:0]  cmd_opb,
   input  logic [3:0]  cmd_fun,
   output logic [7:0]  tx_byte,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_byte,
   input  logic        rx_valid,
   output logic        rsp_valid,
   output logic [15:0] rsp_data,
   output logic        rsp_timeout,
   output logic        rx_drop,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_RSP,
      DONE
   } state_t;

   state_t state, state_nxt;

   logic [1:0] op;
   logic [7:0] addr;
   logic [7:0] wdata;
   logic [7:0] opb;
   logic [3:0] fun;
   logic [1:0] byte_idx;
   logic [1:0] rsp_idx;
   logic [7:0] rsp_b0;

   logic [1:0] last_idx;
   logic [1:0] rsp_cnt;
   logic       accept;
   logic       tx_fire;
   logic       tx_last;
   logic       rx_take;
   logic       rsp_last;
   logic       tmo;

   if (TIMEOUT_CYC >= (1 << TO_W)) begin : g_bad_cfg
      $error("TIMEOUT_CYC does not fit in TO_W bits");
   end

   // Frame length (as last byte index) and response byte count per op
   always_comb begin
      last_idx = 2'd0;
      rsp_cnt  = 2'd0;
      case (op)
         2'd0: begin last_idx = 2'd2; rsp_cnt = 2'd0; end
         2'd1: begin last_idx = 2'd1; rsp_cnt = 2'd1; end
         2'd2: begin last_idx = 2'd3; rsp_cnt = 2'd2; end
         default: begin last_idx = 2'd1; rsp_cnt = 2'd2; end
      endcase
   end

   always_comb begin
      tx_byte = 8'h00;
      if (state == SEND) begin
         case (op)
            2'd0: begin
               case (byte_idx)
                  2'd0: tx_byte = 8'hAA;
                  2'd1: tx_byte = addr;
                  default: tx_byte = wdata;
               endcase
            end
            2'd1: tx_byte = (byte_idx == 2'd0) ? 8'hBB : addr;
            2'd2: begin
               case (byte_idx)
                  2'd0: tx_byte = 8'hCC;
                  2'd1: tx_byte = wdata;
                  2'd2: tx_byte = opb;
                  default: tx_byte = {4'h0, fun};
               endcase
            end
            default: tx_byte = (byte_idx == 2'd0) ? 8'hDD : {4'h0, fun};
         endcase
      end
   end

   assign accept   = (state == IDLE) && cmd_valid;
   assign tx_fire  = (state == SEND) && tx_ready;
   assign tx_last  = tx_fire && (byte_idx == last_idx);
   assign rx_take  = (state == WAIT_RSP) && rx_valid;
   assign rsp_last = rx_take && (rsp_idx == (rsp_cnt - 2'd1));

`ifdef UART_HOST_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt;

   // A byte arriving on the terminal count takes priority over the abort
   assign tmo = (state == WAIT_RSP) && !rx_valid
             && (to_cnt == TO_W'(TIMEOUT_CYC));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         to_cnt <= '0;
      end else if ((state != WAIT_RSP) || rx_valid) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + 1'b1;
      end
   end
`else
   assign tmo = 1'b0;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cmd_ready   = 1'b0;
      busy        = 1'b1;
      tx_valid    = 1'b0;
      rsp_valid   = 1'b0;
      rsp_timeout = 1'b0;
      rx_drop     = rx_valid && (state != WAIT_RSP);
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) state_nxt = SEND;
         end
         SEND: begin
            tx_valid = 1'b1;
            if (tx_last) begin
               state_nxt = (rsp_cnt != 2'd0) ? WAIT_RSP : DONE;
            end
         end
         WAIT_RSP: begin
            rsp_timeout = tmo;
            if (rsp_last) state_nxt = DONE;
            else if (tmo) state_nxt = IDLE;
         end
         default: begin
            rsp_valid = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         op       <= 2'd0;
         addr     <= 8'h00;
         wdata    <= 8'h00;
         opb      <= 8'h00;
         fun      <= 4'h0;
         byte_idx <= 2'd0;
         rsp_idx  <= 2'd0;
         rsp_b0   <= 8'h00;
         rsp_data <= 16'h0000;
      end else begin
         if (accept) begin
            op       <= cmd_op;
            addr     <= cmd_addr;
            wdata    <= cmd_wdata;
            opb      <= cmd_opb;
            fun      <= cmd_fun;
            byte_idx <= 2'd0;
            rsp_idx  <= 2'd0;
         end
         if (tx_fire) byte_idx <= byte_idx + 2'd1;
         if (tx_last && (rsp_cnt == 2'd0)) rsp_data <= 16'h0000;
         if (rx_take) begin
            rsp_idx <= rsp_idx + 2'd1;
            if (rsp_idx == 2'd0) rsp_b0 <= rx_byte;
         end
         // Assembled word lands only on completion; aborts leave it intact
         if (rsp_last) begin
            rsp_data <= (op == 2'd1) ? {8'h00, rx_byte}
                                     : {rx_byte, rsp_b0};
         end
      end
   end

endmodule

// File: doc/uart_host_cmd_master.md
Name: uart_host_cmd_master

Overview:
- Host-side initiator for the UART command protocol served by the system controller.
- Converts one command request into the framed byte sequence and streams it, byte-handshaked, into a UART transmitter.
- Collects the response bytes from a UART receiver and presents one assembled response word.
- Sits at the far end of the UART link: bench host model, or an FPGA-side bridge.

Parameters:
- TIMEOUT_CYC, 65535: CLK cycles allowed between response bytes before abort (only with optional feature).
- TO_W, 16: width of the timeout counter; must satisfy TIMEOUT_CYC < 2^TO_W.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high in IDLE only; command accepted when cmd_valid && cmd_ready
- cmd_op  in  2  0=RF write, 1=RF read, 2=ALU with operands, 3=ALU no operand
- cmd_addr  in  8  register file address byte
- cmd_wdata  in  8  RF write data, or ALU operand A
- cmd_opb  in  8  ALU operand B
- cmd_fun  in  4  ALU function, zero-extended to a byte when sent
- tx_byte  out  8  byte to UART transmitter
- tx_valid  out  1  tx_byte valid; held until tx_ready
- tx_ready  in  1  transmitter accepts byte this cycle
- rx_byte  in  8  received byte
- rx_valid  in  1  single-cycle strobe, rx_byte valid
- rsp_valid  out  1  one-cycle pulse: response complete
- rsp_data  out  16  response; RF read = {8'h00, byte0}; ALU = {byte1, byte0}
- rsp_timeout  out  1  one-cycle pulse: response aborted (optional feature)
- rx_drop  out  1  one-cycle pulse: rx byte received outside WAIT_RSP
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: tx_valid=0, tx_byte=0, rsp_valid=0, rsp_data=0, rsp_timeout=0, rx_drop=0, busy=0, cmd_ready=1. State returns to IDLE, counters clear.
- Reset mid-frame aborts immediately. No partial frame completion.
- Frame format, by cmd_op:
  - op0: AA, addr, wdata. 3 bytes, 0 response bytes.
  - op1: BB, addr. 2 bytes, 1 response byte.
  - op2: CC, A, B, {4'h0, fun}. 4 bytes, 2 response bytes.
  - op3: DD, {4'h0, fun}. 2 bytes, 2 response bytes.
- Command fields are registered on acceptance. Later input changes are ignored.
- FSM states: IDLE, SEND, WAIT_RSP, DONE.
- IDLE:
  - On accept: go to SEND, byte_idx=0.
  - tx_byte is driven with byte 0 in the cycle after acceptance, with tx_valid=1.
- SEND:
  - On tx_valid && tx_ready: byte_idx increments and the next byte is presented the following cycle. tx_valid stays high; bytes are back-to-back.
  - tx_byte is stable while tx_valid && !tx_ready.
  - After the last byte handshake: go to WAIT_RSP if the op expects a response, otherwise to DONE.
- WAIT_RSP:
  - Each rx_valid stores rx_byte at rsp_idx, with LSB first.
  - When the expected count is reached, go to DONE.
  - An rx_valid in the same cycle as the final tx handshake is dropped (rx_drop), since the state is still SEND.
- DONE: one cycle.
  - rsp_valid=1 with rsp_data final; for op0, rsp_data=0.
  - Then go to IDLE.
  - rsp_data holds its value until the next DONE.
- rx_valid in IDLE, SEND or DONE: byte discarded, rx_drop pulses.
- Command-to-first-byte latency: 1 cycle. Last response byte to rsp_valid: 1 cycle.

Optional Feature:
- Macro: UART_HOST_TIMEOUT_EN.
- Defined:
  - In WAIT_RSP, the counter clears on entry and on each rx_valid, otherwise increments.
  - When it equals TIMEOUT_CYC: rsp_timeout pulses, rsp_valid does not pulse, partial bytes are discarded (rsp_data unchanged), and the FSM returns to IDLE.
  - rx_valid in the same cycle as the terminal count wins: the byte is accepted and the counter clears.
- Undefined: no counter. WAIT_RSP waits indefinitely. rsp_timeout is tied 0.

Test Plan:
- op0 addr=05 wdata=3C, tx_ready=1 -> tx bytes AA,05,3C on consecutive cycles; rsp_valid 1 cycle later with rsp_data=0000; no rx needed.
- op1 addr=02, tx_ready toggled 1/0 -> BB,02 each held stable while stalled; rx 81 -> rsp_data=0081, rsp_valid pulse, busy falls next cycle.
- op2 A=10 B=20 fun=0 -> CC,10,20,00; rx 30 then 00 -> rsp_data=0030.
- op3 fun=3; rx_valid=1 with 77 during SEND -> rx_drop pulse, byte ignored; later rx 34,12 -> rsp_data=1234.
- With UART_HOST_TIMEOUT_EN, TIMEOUT_CYC=20, op1 with no rx -> rsp_timeout at cycle 20 after entering WAIT_RSP, no rsp_valid, cmd_ready=1 next cycle.
- RST asserted mid-SEND of op2 -> tx_valid=0, busy=0, cmd_ready=1 immediately; a following op1 frames correctly (BB first).
